free_slot_list: RTL and testbench

- 32-entry free-slot tracker for the out-of-order core's ROB/RS/PRF tag pools; the inverse partner of the priority encoder.
- Holds a free bitmap. Allocates up to two slots per cycle: port 0 takes the lowest free slot, port 1 the highest.
- Accepts up to two slot releases per cycle as binary indices, decodes them to one-hot and returns them to the bitmap.
- Also tracks the free count and flags illegal releases.

---
 rtl/free_slot_list.sv | 89 ++++++++
 tb/tb_free_slot_list.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/free_slot_list.sv
// free_slot_list: 32-entry free-slot tracker with dual allocate (lowest/highest)
// and dual release, free count, empty flag and illegal-release pulse.
module free_slot_list #(
    parameter int unsigned NUM_ENTRIES = 32,
    parameter int unsigned IDX_W       = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       alloc_req,
    input  logic [1:0]       free_en,
    input  logic [IDX_W-1:0] free_idx0,
    input  logic [IDX_W-1:0] free_idx1,
    output logic [IDX_W-1:0] alloc_idx_low,
    output logic [IDX_W-1:0] alloc_idx_high,
    output logic [1:0]       alloc_valid,
    output logic [1:0]       alloc_gnt,
    output logic [IDX_W:0]   free_count,
    output logic             empty,
    output logic             free_err
);

    localparam int unsigned CNT_W = IDX_W + 1;

    logic [NUM_ENTRIES-1:0] free_mask;
    logic [NUM_ENTRIES-1:0] free_mask_next;
    logic [NUM_ENTRIES-1:0] grant_mask;
    logic [NUM_ENTRIES-1:0] rel_mask;
    logic [CNT_W-1:0]       free_count_next;
    logic                   rel0_ok;
    logic                   rel1_ok;
    logic                   err_next;

    // Lowest and highest free slot; both read 0 when nothing is free.
    always_comb begin
        alloc_idx_low  = '0;
        alloc_idx_high = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (free_mask[i]) alloc_idx_low = IDX_W'(i);
        end
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (free_mask[i]) alloc_idx_high = IDX_W'(i);
        end
    end

    // Port 1 needs two free slots so the two grants never collide.
    always_comb begin
        alloc_valid[0] = (free_count >= CNT_W'(1));
        alloc_valid[1] = (free_count >= CNT_W'(2));
        alloc_gnt      = alloc_req & alloc_valid;
    end

    // Grant/release decode, legality checks and next-state computation.
    always_comb begin
        grant_mask = '0;
        if (alloc_gnt[0]) grant_mask[alloc_idx_low]  = 1'b1;
        if (alloc_gnt[1]) grant_mask[alloc_idx_high] = 1'b1;

        rel0_ok = free_en[0] && !free_mask[free_idx0] && !grant_mask[free_idx0];
        // On a duplicate index port 0 wins and port 1 is the offender.
        rel1_ok = free_en[1] && !free_mask[free_idx1] && !grant_mask[free_idx1]
                  && !(free_en[0] && (free_idx0 == free_idx1));

        rel_mask = '0;
        if (rel0_ok) rel_mask[free_idx0] = 1'b1;
        if (rel1_ok) rel_mask[free_idx1] = 1'b1;

        err_next = (free_en[0] && !rel0_ok) || (free_en[1] && !rel1_ok);

        free_mask_next  = (free_mask & ~grant_mask) | rel_mask;
        free_count_next = free_count + CNT_W'(rel0_ok) + CNT_W'(rel1_ok)
                          - CNT_W'(alloc_gnt[0]) - CNT_W'(alloc_gnt[1]);
    end

    // State and status registers; reset overrides any same-cycle activity.
    always_ff @(posedge clock) begin
        if (reset) begin
            free_mask  <= '1;
            free_count <= CNT_W'(NUM_ENTRIES);
            empty      <= 1'b0;
            free_err   <= 1'b0;
        end else begin
            free_mask  <= free_mask_next;
            free_count <= free_count_next;
            empty      <= (free_count_next == '0);
            free_err   <= err_next;
        end
    end

endmodule

// File: tb/tb_free_slot_list.sv
// tb_free_slot_list: directed vector table plus randomized run against a
// slot-array reference model.
module tb_free_slot_list;

    localparam int unsigned N  = 32;
    localparam int unsigned IW = 5;

    logic          clock;
    logic          reset;
    logic [1:0]    alloc_req;
    logic [1:0]    free_en;
    logic [IW-1:0] free_idx0;
    logic [IW-1:0] free_idx1;
    logic [IW-1:0] alloc_idx_low;
    logic [IW-1:0] alloc_idx_high;
    logic [1:0]    alloc_valid;
    logic [1:0]    alloc_gnt;
    logic [IW:0]   free_count;
    logic          empty;
    logic          free_err;

    int checks = 0;
    int errors = 0;

    free_slot_list #(.NUM_ENTRIES(N), .IDX_W(IW)) dut (
        .clock(clock), .reset(reset),
        .alloc_req(alloc_req), .free_en(free_en),
        .free_idx0(free_idx0), .free_idx1(free_idx1),
        .alloc_idx_low(alloc_idx_low), .alloc_idx_high(alloc_idx_high),
        .alloc_valid(alloc_valid), .alloc_gnt(alloc_gnt),
        .free_count(free_count), .empty(empty), .free_err(free_err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [1:0] req;
        logic [1:0] fen;
        int         i0;
        int         i1;
        logic [1:0] gnt;
        int         lo;
        int         hi;
        logic [1:0] vld;
        int         cnt;
        logic       emp;
        logic       err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [1:0] req, logic [1:0] fen, int i0, int i1,
                                logic [1:0] gnt, int lo, int hi, logic [1:0] vld,
                                int cnt, logic emp, logic err);
        vec_t v;
        v.req = req; v.fen = fen; v.i0 = i0; v.i1 = i1;
        v.gnt = gnt; v.lo = lo; v.hi = hi; v.vld = vld;
        v.cnt = cnt; v.emp = emp; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    // Reference model: one bit per slot, everything else derived by counting.
    bit mfree[N];
    bit merr;

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(mfree[i]);
        return c;
    endfunction

    function automatic int m_low();
        for (int i = 0; i < N; i++) if (mfree[i]) return i;
        return 0;
    endfunction

    function automatic int m_high();
        for (int i = N - 1; i >= 0; i--) if (mfree[i]) return i;
        return 0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) mfree[i] = 1'b1;
        merr = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v, input int k);
        @(negedge clock);
        alloc_req = v.req; free_en = v.fen;
        free_idx0 = IW'(v.i0); free_idx1 = IW'(v.i1);
        #1;
        chk("tbl_gnt", k, int'(alloc_gnt), int'(v.gnt));
        chk("tbl_low", k, int'(alloc_idx_low), v.lo);
        chk("tbl_high", k, int'(alloc_idx_high), v.hi);
        chk("tbl_valid", k, int'(alloc_valid), int'(v.vld));
        @(posedge clock);
        #1;
        chk("tbl_count", k, int'(free_count), v.cnt);
        chk("tbl_empty", k, int'(empty), int'(v.emp));
        chk("tbl_err", k, int'(free_err), int'(v.err));
    endtask

    initial begin
        reset = 1'b1; alloc_req = '0; free_en = '0; free_idx0 = '0; free_idx1 = '0;

        // Directed table (follows from reset state).
        tbl.push_back(mk(2'b11, 2'b00, 0, 0, 2'b11, 0, 31, 2'b11, 30, 1'b0, 1'b0));
        tbl.push_back(mk(2'b11, 2'b00, 0, 0, 2'b11, 1, 30, 2'b11, 28, 1'b0, 1'b0));
        tbl.push_back(mk(2'b11, 2'b00, 0, 0, 2'b11, 2, 29, 2'b11, 26, 1'b0, 1'b0));
        for (int l = 3; l <= 14; l++)
            tbl.push_back(mk(2'b11, 2'b00, 0, 0, 2'b11, l, 31 - l, 2'b11,
                             24 - 2 * (l - 3), 1'b0, 1'b0));
        tbl.push_back(mk(2'b10, 2'b00, 0, 0, 2'b10, 15, 16, 2'b11, 1, 1'b0, 1'b0));
        tbl.push_back(mk(2'b11, 2'b00, 0, 0, 2'b01, 15, 15, 2'b01, 0, 1'b1, 1'b0));
        tbl.push_back(mk(2'b11, 2'b11, 7, 20, 2'b00, 0, 0, 2'b00, 2, 1'b0, 1'b0));
        tbl.push_back(mk(2'b00, 2'b00, 0, 0, 2'b00, 7, 20, 2'b11, 2, 1'b0, 1'b0));
        tbl.push_back(mk(2'b00, 2'b01, 3, 0, 2'b00, 7, 20, 2'b11, 3, 1'b0, 1'b0));
        tbl.push_back(mk(2'b00, 2'b01, 3, 0, 2'b00, 3, 20, 2'b11, 3, 1'b0, 1'b1));
        tbl.push_back(mk(2'b00, 2'b00, 0, 0, 2'b00, 3, 20, 2'b11, 3, 1'b0, 1'b0));
        tbl.push_back(mk(2'b00, 2'b11, 9, 9, 2'b00, 3, 20, 2'b11, 4, 1'b0, 1'b1));
        tbl.push_back(mk(2'b01, 2'b01, 3, 0, 2'b01, 3, 20, 2'b11, 3, 1'b0, 1'b1));
        tbl.push_back(mk(2'b01, 2'b01, 10, 0, 2'b01, 7, 20, 2'b11, 3, 1'b0, 1'b0));
        tbl.push_back(mk(2'b00, 2'b00, 0, 0, 2'b00, 9, 20, 2'b11, 3, 1'b0, 1'b0));

        repeat (2) @(posedge clock);
        #1;
        chk("rst_count", 0, int'(free_count), 32);
        chk("rst_empty", 0, int'(empty), 0);
        chk("rst_err", 0, int'(free_err), 0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst_low", 0, int'(alloc_idx_low), 0);
        chk("rst_high", 0, int'(alloc_idx_high), 31);
        chk("rst_valid", 0, int'(alloc_valid), 3);

        foreach (tbl[k]) apply_vec(tbl[k], k);

        // Reset mid-burst with grants and a duplicate release pending.
        @(negedge clock);
        reset = 1'b1; alloc_req = 2'b11; free_en = 2'b11;
        free_idx0 = IW'(9); free_idx1 = IW'(9);
        @(posedge clock);
        #1;
        chk("mid_rst_count", 0, int'(free_count), 32);
        chk("mid_rst_err", 0, int'(free_err), 0);
        chk("mid_rst_empty", 0, int'(empty), 0);
        @(negedge clock);
        reset = 1'b0; alloc_req = '0; free_en = '0;
        #1;
        chk("mid_rst_low", 0, int'(alloc_idx_low), 0);
        chk("mid_rst_high", 0, int'(alloc_idx_high), 31);
        chk("mid_rst_valid", 0, int'(alloc_valid), 3);

        // Randomized run against the model.
        m_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [1:0] req, fen, vld, gnt;
            int i0, i1, lo, hi, cnt;
            bit rst, ok0, ok1;
            bit gmask[N];

            req = 2'($urandom_range(0, 3));
            fen = 2'($urandom_range(0, 3));
            i0  = int'($urandom_range(0, N - 1));
            i1  = ($urandom_range(0, 3) == 0) ? i0 : int'($urandom_range(0, N - 1));
            rst = ($urandom_range(0, 99) == 0);

            cnt = m_count();
            lo  = m_low();
            hi  = m_high();
            vld = {cnt >= 2, cnt >= 1};
            gnt = req & vld;

            @(negedge clock);
            reset = rst; alloc_req = req; free_en = fen;
            free_idx0 = IW'(i0); free_idx1 = IW'(i1);
            #1;
            chk("rnd_low", c, int'(alloc_idx_low), lo);
            chk("rnd_high", c, int'(alloc_idx_high), hi);
            chk("rnd_valid", c, int'(alloc_valid), int'(vld));
            chk("rnd_gnt", c, int'(alloc_gnt), int'(gnt));

            if (rst) begin
                m_reset();
            end else begin
                for (int i = 0; i < N; i++) gmask[i] = 1'b0;
                if (gnt[0]) gmask[lo] = 1'b1;
                if (gnt[1]) gmask[hi] = 1'b1;
                ok0 = fen[0] && !mfree[i0] && !gmask[i0];
                ok1 = fen[1] && !mfree[i1] && !gmask[i1] && !(fen[0] && i0 == i1);
                merr = (fen[0] && !ok0) || (fen[1] && !ok1);
                for (int i = 0; i < N; i++) if (gmask[i]) mfree[i] = 1'b0;
                if (ok0) mfree[i0] = 1'b1;
                if (ok1) mfree[i1] = 1'b1;
            end

            @(posedge clock);
            #1;
            chk("rnd_count", c, int'(free_count), m_count());
            chk("rnd_empty", c, int'(empty), int'(m_count() == 0));
            chk("rnd_err", c, int'(free_err), int'(merr));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
